// File: rtl/dyn_concat_seq.sv
// rtl/dyn_concat_seq.sv - clocked select-and-concatenate list builder with valid/ready stream out
// Optional packed snapshot outputs (out_vec/out_cnt) enabled by DYN_CONCAT_SEQ_PACKED_OUT_EN.
module dyn_concat_seq #(
  parameter int DW     = 4,
  parameter int NSRC   = 4,
  parameter int MAXLEN = 8,
  parameter int SELW   = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [SELW-1:0]        wr_idx,
  input  logic [DW-1:0]          wr_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LW-1:0]          cmd_len,
  input  logic [MAXLEN*SELW-1:0] cmd_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_last,
  output logic                   err,
  output logic [MAXLEN*DW-1:0]   out_vec,
  output logic [LW-1:0]          out_cnt
);

  localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_STREAM} state_e;

  state_e                 state_q;
  logic [DW-1:0]          src_q [NSRC];
  logic [DW-1:0]          buf_q [MAXLEN];
  logic [DW-1:0]          buf_d [MAXLEN];
  logic [LW-1:0]          len_q;
  logic [MAXLEN*SELW-1:0] sel_q;
  logic [IW-1:0]          k_q;
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_nxt;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [DW-1:0]          out_data_q;
  logic                   err_q;
  logic [SELW-1:0]        cur_sel;
  logic [DW-1:0]          cur_elem;
  logic                   cur_oob;
  logic                   build_last;

  assign cmd_ready = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

  // Source lookup for the element being copied; the buffer with that copy applied feeds the
  // BUILD->STREAM transition so a one-element list can present its data on the same edge.
  always_comb begin
    cur_sel  = sel_q[k_q*SELW +: SELW];
    cur_elem = '0;
    cur_oob  = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (cur_sel == SELW'(i)) begin
        cur_elem = src_q[i];
        cur_oob  = 1'b0;
      end
    end
    build_last = ((LW'(k_q) + LW'(1)) == len_q);
    ptr_nxt    = ptr_q + IW'(1);
    for (int i = 0; i < MAXLEN; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (state_q == S_BUILD) begin
      buf_d[k_q] = cur_elem;
    end
  end

  // Source element registers; writes land in any state, out-of-range indices match nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        src_q[i] <= DW'(i + 1);
      end
    end else if (wr_en) begin
      for (int i = 0; i < NSRC; i++) begin
        if (wr_idx == SELW'(i)) begin
          src_q[i] <= wr_data;
        end
      end
    end
  end

  // Command accept, one-element-per-cycle build, then stream with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < MAXLEN; i++) begin
        buf_q[i] <= '0;
      end
      len_q       <= '0;
      sel_q       <= '0;
      k_q         <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if ((cmd_len == '0) || (int'(cmd_len) > MAXLEN)) begin
              err_q <= 1'b1;
            end else begin
              len_q   <= cmd_len;
              sel_q   <= cmd_sel;
              err_q   <= 1'b0;
              k_q     <= '0;
              for (int i = 0; i < MAXLEN; i++) begin
                buf_q[i] <= '0;
              end
              state_q <= S_BUILD;
            end
          end
        end
        S_BUILD: begin
          buf_q <= buf_d;
          k_q   <= k_q + IW'(1);
          if (cur_oob) begin
            err_q <= 1'b1;
          end
          if (build_last) begin
            state_q     <= S_STREAM;
            out_valid_q <= 1'b1;
            out_data_q  <= buf_d[0];
            out_last_q  <= (len_q == LW'(1));
            ptr_q       <= '0;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              ptr_q      <= ptr_nxt;
              out_data_q <= buf_q[ptr_nxt];
              out_last_q <= ((LW'(ptr_nxt) + LW'(1)) == len_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DYN_CONCAT_SEQ_PACKED_OUT_EN
  logic [MAXLEN*DW-1:0] vec_q;
  logic [LW-1:0]        cnt_q;

  // Snapshot of the completed list, refreshed only when a build finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else if ((state_q == S_BUILD) && build_last) begin
      for (int i = 0; i < MAXLEN; i++) begin
        vec_q[i*DW +: DW] <= buf_d[i];
      end
      cnt_q <= len_q;
    end
  end

  assign out_vec = vec_q;
  assign out_cnt = cnt_q;
`else
  assign out_vec = '0;
  assign out_cnt = '0;
`endif

endmodule
